// File: rtl/fetch_unit.sv
// Instruction fetch unit.
// Issues one word request at a time to instruction memory, queues up to two
// fetched {instr, pc} pairs and presents the oldest to decode. A redirect
// realigns the fetch address, flushes the queue and discards any reply that
// is still in flight.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   mem_req         fetch request (held until mem_ack)
//   mem_addr        byte address of the request
//   mem_ack         memory accepts the request; mem_rdata valid this cycle
//   mem_rdata       fetched instruction word
//   redirect_valid  control-flow change request
//   redirect_pc     new fetch address (word-aligned internally)
//   instr_valid     queue head holds a valid instruction
//   instr_ready     downstream consumes the head
//   instr           head instruction word
//   instr_pc        byte address of the head instruction
module fetch_unit #(
    parameter int unsigned              ADDR_WIDTH = 16,
    parameter int unsigned              DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]    RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0] instr_pc
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t                state;
    logic                  started;
    logic [ADDR_WIDTH-1:0] fetch_pc;

    // Second queue slot; the head slot is the instr/instr_pc output register.
    logic                  q1_valid;
    logic [DATA_WIDTH-1:0] q1_data;
    logic [ADDR_WIDTH-1:0] q1_pc;

    logic                  ack;
    logic                  pop;
    logic                  push;
    logic                  full;
    logic [ADDR_WIDTH-1:0] redirect_aligned;

    // mem_ack only counts while a request is actually on the bus.
    assign ack              = mem_req & mem_ack;
    assign pop              = instr_valid & instr_ready;
    assign push             = (state == WAIT) & ack & ~redirect_valid;
    assign full             = instr_valid & q1_valid;
    assign redirect_aligned = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            started     <= 1'b0;
            fetch_pc    <= RESET_PC;
            mem_req     <= 1'b0;
            mem_addr    <= RESET_PC;
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
            q1_valid    <= 1'b0;
            q1_data     <= '0;
            q1_pc       <= '0;
        end else begin
            // One idle cycle after reset release before the first request.
            started <= 1'b1;

            // Request FSM: a single request outstanding at most.
            case (state)
                IDLE: begin
                    if (!redirect_valid && started && !full) begin
                        mem_req  <= 1'b1;
                        mem_addr <= fetch_pc;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (ack) begin
                        mem_req <= 1'b0;
                        state   <= IDLE;
                    end else if (redirect_valid) begin
                        state <= DROP;
                    end
                end
                DROP: begin
                    if (ack) begin
                        mem_req <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    mem_req <= 1'b0;
                    state   <= IDLE;
                end
            endcase

            // Fetch address: redirect wins over sequential advance.
            if (redirect_valid) begin
                fetch_pc <= redirect_aligned;
            end else if (push) begin
                fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
            end

            // Two-entry queue; redirect flushes and overrides push/pop.
            if (redirect_valid) begin
                instr_valid <= 1'b0;
                q1_valid    <= 1'b0;
            end else if (push && pop) begin
                if (q1_valid) begin
                    instr    <= q1_data;
                    instr_pc <= q1_pc;
                    q1_data  <= mem_rdata;
                    q1_pc    <= mem_addr;
                end else begin
                    instr    <= mem_rdata;
                    instr_pc <= mem_addr;
                end
            end else if (pop) begin
                instr       <= q1_data;
                instr_pc    <= q1_pc;
                instr_valid <= q1_valid;
                q1_valid    <= 1'b0;
            end else if (push) begin
                if (!instr_valid) begin
                    instr       <= mem_rdata;
                    instr_pc    <= mem_addr;
                    instr_valid <= 1'b1;
                end else begin
                    q1_data  <= mem_rdata;
                    q1_pc    <= mem_addr;
                    q1_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed cycle-by-cycle bench for fetch_unit: a table of per-cycle inputs
// and hand-computed outputs, followed by an asynchronous-reset sequence.
module tb_fetch_unit;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 32;

    logic          clk;
    logic          rst_n;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          instr_valid;
    logic          instr_ready;
    logic [DW-1:0] instr;
    logic [AW-1:0] instr_pc;

    int checks = 0;
    int errors = 0;

    fetch_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESET_PC(16'h0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          ack;
        logic [DW-1:0] rdata;
        logic          redir;
        logic [AW-1:0] rpc;
        logic          ready;
        logic          e_req;
        logic [AW-1:0] e_addr;
        logic          e_valid;
        logic [AW-1:0] e_pc;
        logic [DW-1:0] e_instr;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [DW-1:0] word(input logic [AW-1:0] a);
        return 32'hA500_0000 | DW'(a);
    endfunction

    task automatic add(input logic ack, input logic [DW-1:0] rdata,
                       input logic redir, input logic [AW-1:0] rpc,
                       input logic ready, input logic e_req,
                       input logic [AW-1:0] e_addr, input logic e_valid,
                       input logic [AW-1:0] e_pc, input logic [DW-1:0] e_instr);
        vec_t v;
        v.ack = ack; v.rdata = rdata; v.redir = redir; v.rpc = rpc;
        v.ready = ready; v.e_req = e_req; v.e_addr = e_addr;
        v.e_valid = e_valid; v.e_pc = e_pc; v.e_instr = e_instr;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic ack, input logic [DW-1:0] rdata,
                         input logic redir, input logic [AW-1:0] rpc,
                         input logic ready);
        mem_ack        = ack;
        mem_rdata      = rdata;
        redirect_valid = redir;
        redirect_pc    = rpc;
        instr_ready    = ready;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Head data is only compared when valid, unless chk_data forces it.
    task automatic check(input string name, input logic e_req,
                         input logic [AW-1:0] e_addr, input logic e_valid,
                         input logic [AW-1:0] e_pc, input logic [DW-1:0] e_instr,
                         input logic chk_data);
        checks++;
        if (mem_req !== e_req) begin
            errors++;
            $display("FAIL %s mem_req: got %0b want %0b", name, mem_req, e_req);
        end
        checks++;
        if (mem_req && mem_addr !== e_addr || !mem_req && e_req == 1'b0 && mem_addr !== e_addr) begin
            errors++;
            $display("FAIL %s mem_addr: got %h want %h", name, mem_addr, e_addr);
        end
        checks++;
        if (instr_valid !== e_valid) begin
            errors++;
            $display("FAIL %s instr_valid: got %0b want %0b", name, instr_valid, e_valid);
        end
        if (e_valid || chk_data) begin
            checks++;
            if (instr_pc !== e_pc) begin
                errors++;
                $display("FAIL %s instr_pc: got %h want %h", name, instr_pc, e_pc);
            end
            checks++;
            if (instr !== e_instr) begin
                errors++;
                $display("FAIL %s instr: got %h want %h", name, instr, e_instr);
            end
        end
    endtask

    initial begin
        // ack rdata redir rpc ready | req addr valid pc instr
        // Sequential fetch with memory acking the cycle after issue.
        add(0, '0,          0, '0,      1,  0, 16'h0000, 0, '0, '0);        // v0 first edge: no request yet
        add(0, '0,          0, '0,      1,  1, 16'h0000, 0, '0, '0);        // v1 first request
        add(1, word(16'h0), 0, '0,      1,  0, 16'h0000, 1, 16'h0000, word(16'h0000));
        add(0, '0,          0, '0,      1,  1, 16'h0004, 0, '0, '0);
        add(1, word(16'h4), 0, '0,      1,  0, 16'h0004, 1, 16'h0004, word(16'h0004));
        add(0, '0,          0, '0,      1,  1, 16'h0008, 0, '0, '0);
        add(1, word(16'h8), 0, '0,      1,  0, 16'h0008, 1, 16'h0008, word(16'h0008));
        // Backpressure: fill both slots, then no further requests.
        add(0, '0,          0, '0,      0,  1, 16'h000C, 1, 16'h0008, word(16'h0008));
        add(1, word(16'hC), 0, '0,      0,  0, 16'h000C, 1, 16'h0008, word(16'h0008));
        add(0, '0,          0, '0,      0,  0, 16'h000C, 1, 16'h0008, word(16'h0008));
        add(1, 32'h1111_1111, 0, '0,    0,  0, 16'h000C, 1, 16'h0008, word(16'h0008)); // stray ack ignored
        add(0, '0,          0, '0,      1,  0, 16'h000C, 1, 16'h000C, word(16'h000C)); // drain in order
        add(0, '0,          0, '0,      1,  1, 16'h0010, 0, '0, '0);
        add(1, word(16'h10), 0, '0,     1,  0, 16'h0010, 1, 16'h0010, word(16'h0010));
        // Redirect to 0x0103 while waiting; ack three cycles later is dropped.
        add(0, '0,          0, '0,      0,  1, 16'h0014, 1, 16'h0010, word(16'h0010));
        add(0, '0,          1, 16'h0103, 0, 1, 16'h0014, 0, '0, '0);
        add(0, '0,          0, '0,      0,  1, 16'h0014, 0, '0, '0);
        add(0, '0,          0, '0,      0,  1, 16'h0014, 0, '0, '0);
        add(1, 32'hDEAD_BEEF, 0, '0,    0,  0, 16'h0014, 0, '0, '0);
        add(0, '0,          0, '0,      0,  1, 16'h0100, 0, '0, '0);
        add(1, word(16'h100), 0, '0,    1,  0, 16'h0100, 1, 16'h0100, word(16'h0100));
        // Same-cycle ack, pop and redirect to 0x0040.
        add(0, '0,          0, '0,      0,  1, 16'h0104, 1, 16'h0100, word(16'h0100));
        add(1, word(16'h104), 1, 16'h0040, 1, 0, 16'h0104, 0, '0, '0);
        add(0, '0,          0, '0,      1,  1, 16'h0040, 0, '0, '0);
        add(1, word(16'h40), 0, '0,     0,  0, 16'h0040, 1, 16'h0040, word(16'h0040));
        // Redirect in IDLE to 0xFFFE (aligned 0xFFFC), then address wrap.
        add(0, '0,          1, 16'hFFFE, 0, 0, 16'h0040, 0, '0, '0);
        add(0, '0,          0, '0,      0,  1, 16'hFFFC, 0, '0, '0);
        add(1, word(16'hFFFC), 0, '0,   0,  0, 16'hFFFC, 1, 16'hFFFC, word(16'hFFFC));
        add(0, '0,          0, '0,      1,  1, 16'h0000, 0, '0, '0);
        add(1, word(16'h0), 0, '0,      0,  0, 16'h0000, 1, 16'h0000, word(16'h0000));
        // Two redirects while dropping: the later one wins.
        add(0, '0,          0, '0,      0,  1, 16'h0004, 1, 16'h0000, word(16'h0000));
        add(0, '0,          1, 16'h0200, 0, 1, 16'h0004, 0, '0, '0);
        add(0, '0,          1, 16'h0308, 0, 1, 16'h0004, 0, '0, '0);
        add(1, 32'h0BAD_BAD0, 0, '0,    0,  0, 16'h0004, 0, '0, '0);
        add(0, '0,          0, '0,      0,  1, 16'h0308, 0, '0, '0);
        add(1, word(16'h308), 0, '0,    0,  0, 16'h0308, 1, 16'h0308, word(16'h0308));

        // Reset
        drive(0, '0, 0, '0, 0);
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1 check("reset", 0, 16'h0000, 0, 16'h0000, 32'h0, 1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].ack, vecs[i].rdata, vecs[i].redir, vecs[i].rpc, vecs[i].ready);
            step();
            check($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr,
                  vecs[i].e_valid, vecs[i].e_pc, vecs[i].e_instr, 0);
        end

        // Asynchronous reset while a request is outstanding.
        drive(0, '0, 0, '0, 0);
        step();
        check("pre_rst", 1, 16'h030C, 1, 16'h0308, word(16'h0308), 0);
        #2 rst_n = 1'b0;
        #1 check("async_rst", 0, 16'h0000, 0, 16'h0000, 32'h0, 1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("rst_edge1", 0, 16'h0000, 0, '0, '0, 0);
        step();
        check("rst_edge2", 1, 16'h0000, 0, '0, '0, 0);
        drive(1, word(16'h0), 0, '0, 1);
        step();
        check("rst_fetch", 0, 16'h0000, 1, 16'h0000, word(16'h0000), 0);
        drive(0, '0, 0, '0, 1);
        step();
        check("rst_next", 1, 16'h0004, 0, '0, '0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The module SHALL have parameter ADDR_WIDTH, default 16, instruction address width.
REQ-002 The module SHALL have parameter DATA_WIDTH, default 32, instruction word width.
REQ-003 The module SHALL have parameter RESET_PC, default 0, first fetch address after reset.
REQ-004 The module SHALL have a single clock and an asynchronous active-low reset, exposed as the first two ports below.
REQ-005 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The module SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 The module SHALL have port mem_req, output, 1 bit: fetch request to instruction memory.
REQ-008 The module SHALL have port mem_addr, output, ADDR_WIDTH bits: byte address of the request.
REQ-009 The module SHALL have port mem_ack, input, 1 bit: memory accepted the request; mem_rdata is valid this cycle.
REQ-010 The module SHALL have port mem_rdata, input, DATA_WIDTH bits: fetched instruction word.
REQ-011 The module SHALL have port redirect_valid, input, 1 bit: control-flow change request.
REQ-012 The module SHALL have port redirect_pc, input, ADDR_WIDTH bits: new fetch address.
REQ-013 The module SHALL have port instr_valid, output, 1 bit: queue head holds a valid instruction.
REQ-014 The module SHALL have port instr_ready, input, 1 bit: downstream decode/execute consumes the head.
REQ-015 The module SHALL have port instr, output, DATA_WIDTH bits: head instruction word.
REQ-016 The module SHALL have port instr_pc, output, ADDR_WIDTH bits: byte address of the head instruction.

Function
REQ-017 The module SHALL hold a fetch_pc register and a 2-entry FIFO queue of {instr, pc} pairs.
REQ-018 The module SHALL use a 3-state FSM: IDLE (no request outstanding), WAIT (request outstanding), DROP (outstanding request to be discarded).
REQ-019 IDLE -> WAIT: when no redirect and queue occupancy < 2, the module SHALL assert mem_req the next cycle with mem_addr = fetch_pc.
REQ-020 In WAIT and DROP, mem_req and mem_addr SHALL remain stable until the cycle mem_ack is high; mem_ack SHALL be ignored while mem_req is low.
REQ-021 At most one request SHALL be outstanding at any time.
REQ-022 WAIT with mem_ack and no redirect: the module SHALL push {mem_rdata, mem_addr}, set fetch_pc = fetch_pc + 4 modulo 2^ADDR_WIDTH, and go to IDLE with mem_req low the next cycle.
REQ-023 A push SHALL raise instr_valid on the cycle after the ack, i.e. 1 cycle of ack-to-valid latency.
REQ-024 A pop SHALL occur when instr_valid and instr_ready are both high; simultaneous push and pop SHALL be legal and occupancy SHALL be unchanged.
REQ-025 No push SHALL ever occur while the queue is full, because the issue rule in REQ-019 guarantees a free slot.
REQ-026 instr and instr_pc SHALL be held stable while instr_valid is high and instr_ready is low.
REQ-027 A redirect SHALL set fetch_pc = {redirect_pc[ADDR_WIDTH-1:2], 2'b00} and flush the queue, so instr_valid is low the next cycle.
REQ-028 A redirect in IDLE SHALL keep the FSM in IDLE.
REQ-029 A redirect in WAIT without mem_ack SHALL move the FSM to DROP.
REQ-030 A redirect in WAIT with mem_ack SHALL discard the data and move the FSM to IDLE.
REQ-031 A redirect SHALL take priority over a same-cycle mem_ack push and a same-cycle pop.
REQ-032 DROP with mem_ack SHALL discard mem_rdata and move to IDLE; a further redirect in DROP SHALL update fetch_pc only.
REQ-033 After a redirect, the first instruction delivered SHALL have instr_pc equal to the aligned redirect_pc.

Reset
REQ-034 Asserting rst_n low SHALL immediately set mem_req = 0, mem_addr = RESET_PC, instr_valid = 0, instr = 0, instr_pc = 0, fetch_pc = RESET_PC, queue empty, FSM = IDLE.
REQ-035 The first mem_req SHALL assert on the second rising edge after rst_n deasserts.
REQ-036 Reset mid-transaction SHALL abandon any outstanding request without waiting for mem_ack.

Verification
REQ-037 Reset release with memory acking every request the cycle after it is issued and instr_ready = 1 -> instr_pc sequence 0x0000, 0x0004, 0x0008, each word matching memory.
REQ-038 instr_ready = 0 held -> exactly 2 entries queued, mem_req stays low afterwards; after instr_ready rises, entries drain in order with no loss.
REQ-039 Redirect to 0x0103 while in WAIT, ack 3 cycles later -> the stale word is dropped and the next delivered instr_pc = 0x0100.
REQ-040 Same-cycle mem_ack, pop and redirect to 0x0040 -> queue empty, no push, next mem_addr = 0x0040.
REQ-041 fetch_pc = 0xFFFC followed by an ack -> the next mem_addr = 0x0000.
REQ-042 rst_n pulsed low during WAIT -> all outputs take their reset values asynchronously and fetch restarts at RESET_PC.
